// File: rtl/mult_booth_seq_pkg.sv
//------------------------------------------------------------------------------
// Module : mult_pkg
// Brief  : Shared FSM encoding and width helpers for the Booth multiplier.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mult_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

    // Widths for the default 12x8 configuration; the helpers below serve other sizes.
    localparam int MBITS_DEF = 12;
    localparam int NBITS_DEF = 8;
    localparam int PW        = MBITS_DEF + NBITS_DEF;
    localparam int CW        = $clog2(NBITS_DEF + 2);

    function automatic int prod_width(input int mbits, input int nbits);
        return mbits + nbits;
    endfunction

    function automatic int cnt_width(input int nbits);
        return $clog2(nbits + 2);
    endfunction

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_booth_seq_booth_step.sv
//------------------------------------------------------------------------------
// Module : booth_step
// Brief  : One radix-2 Booth iteration: add/sub on (Q0,q_1), then arithmetic shift.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module booth_step
    import mult_pkg::*;
#(
    parameter int MBITS = 12,
    parameter int NBITS = 8
) (
    input  logic [MBITS:0] a_i,
    input  logic [MBITS:0] m_i,
    input  logic [NBITS:0] q_i,
    input  logic           q1_i,
    output logic [MBITS:0] a_o,
    output logic [NBITS:0] q_o,
    output logic           q1_o
);

    logic [MBITS:0] w_sum;

    always_comb begin
        w_sum = a_i;
        case ({q_i[0], q1_i})
            2'b01:   w_sum = a_i + m_i;
            2'b10:   w_sum = a_i - m_i;
            default: w_sum = a_i;
        endcase
        {a_o, q_o, q1_o} = {w_sum[MBITS], w_sum, q_i};
    end

endmodule : booth_step

`default_nettype wire

// File: rtl/mult_booth_seq.sv
//------------------------------------------------------------------------------
// Module : mult_booth_seq
// Brief  : Sequential radix-2 Booth multiplier, signed/unsigned per operation.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mult_booth_seq
    import mult_pkg::*;
#(
    parameter int MBITS = 12,
    parameter int NBITS = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   tc,
    input  logic [MBITS-1:0]       mpd,
    input  logic [NBITS-1:0]       mpr,
    output logic [MBITS+NBITS-1:0] prod,
    output logic                   busy,
    output logic                   done
);

    localparam int c_PW = prod_width(MBITS, NBITS);
    localparam int c_CW = cnt_width(NBITS);

    state_t            state_q, state_d;
    logic [c_CW-1:0]   cnt_q,   cnt_d;
    logic [MBITS:0]    a_q,     a_d;
    logic [MBITS:0]    m_q,     m_d;
    logic [NBITS:0]    q_q,     q_d;
    logic              q1_q,    q1_d;
    logic              tc_q,    tc_d;
    logic [c_PW-1:0]   prod_q,  prod_d;
    logic              busy_q,  busy_d;
    logic              done_q,  done_d;

    logic [MBITS:0]    w_a;
    logic [NBITS:0]    w_q;
    logic              w_q1;
    logic [c_PW+1:0]   w_aq;
    logic              w_unused_msb;

    booth_step #(
        .MBITS (MBITS),
        .NBITS (NBITS)
    ) u_step (
        .a_i  (a_q),
        .m_i  (m_q),
        .q_i  (q_q),
        .q1_i (q1_q),
        .a_o  (w_a),
        .q_o  (w_q),
        .q1_o (w_q1)
    );

    // Signed runs take NBITS steps, leaving the product one bit above the
    // register LSB (Q0 still holds the multiplier's extension bit); unsigned
    // runs take NBITS+1 steps and the product lands at bit 0.
    assign w_aq         = {w_a, w_q};
    assign w_unused_msb = w_aq[c_PW+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            tc_q    <= 1'b0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            tc_q    <= tc_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        q1_d    = q1_q;
        tc_d    = tc_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    m_d     = {tc & mpd[MBITS-1], mpd};
                    q_d     = {tc & mpr[NBITS-1], mpr};
                    a_d     = '0;
                    q1_d    = 1'b0;
                    tc_d    = tc;
                    cnt_d   = tc ? c_CW'(NBITS) : c_CW'(NBITS + 1);
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                a_d   = w_a;
                q_d   = w_q;
                q1_d  = w_q1;
                cnt_d = cnt_q - c_CW'(1);
                if (cnt_q == c_CW'(1)) begin
                    prod_d  = tc_q ? w_aq[c_PW:1] : w_aq[c_PW-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign prod = prod_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule : mult_booth_seq

`default_nettype wire

// File: tb/tb_mult_booth_seq.sv
//------------------------------------------------------------------------------
// Module : tb_mult_booth_seq
// Brief  : Directed self-checking bench for mult_booth_seq (12x8).
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mult_booth_seq;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tc    = 1'b0;
    logic [11:0] mpd   = '0;
    logic [7:0]  mpr   = '0;
    logic [19:0] prod;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_booth_seq #(
        .MBITS (12),
        .NBITS (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .tc    (tc),
        .mpd   (mpd),
        .mpr   (mpr),
        .prod  (prod),
        .busy  (busy),
        .done  (done)
    );

    // Launches one operation and returns at the first sample with busy low.
    task automatic do_op(input logic t, input logic [11:0] a, input logic [7:0] b,
                         output int ncyc, output int early_done);
        @(negedge clk);
        tc = t; mpd = a; mpr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; tc = ~t; mpd = ~a; mpr = ~b;
        ncyc = 0;
        early_done = 0;
        while (busy === 1'b1 && ncyc < 40) begin
            ncyc++;
            if (done !== 1'b0) early_done++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; tc = 1'b1; mpd = 12'h7FF; mpr = 8'h7F;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy cyc %0d got %b want 0", i, busy); end
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL reset_done cyc %0d got %b want 0", i, done); end
            checks++;
            if (prod !== 20'h0) begin errors++; $display("FAIL reset_prod cyc %0d got %h want 00000", i, prod); end
        end
        @(negedge clk);
        start = 1'b0; rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b want 0", busy); end
    endtask

    task automatic test_signed_corners();
        logic [11:0] va [2] = '{12'h800, 12'h7FF};
        logic [7:0]  vb [2] = '{8'h80, 8'h81};
        logic [19:0] ve [2] = '{20'h40000, 20'hC087F};  // -2048*-128, 2047*-127
        int n, ed;
        for (int i = 0; i < 2; i++) begin
            do_op(1'b1, va[i], vb[i], n, ed);
            checks++;
            if (prod !== ve[i]) begin errors++; $display("FAIL signed_prod %0d got %h want %h", i, prod, ve[i]); end
            checks++;
            if (n != 8) begin errors++; $display("FAIL signed_busy_cycles %0d got %0d want 8", i, n); end
            checks++;
            if (done !== 1'b1 || ed != 0) begin
                errors++; $display("FAIL signed_done %0d got done=%b early=%0d want 1/0", i, done, ed);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin errors++; $display("FAIL signed_done_width %0d got %b want 0", i, done); end
        end
    endtask

    task automatic test_unsigned();
        int n, ed;
        do_op(1'b0, 12'hFFF, 8'hFF, n, ed);
        checks++;
        if (prod !== 20'hFEF01) begin errors++; $display("FAIL unsigned_prod got %h want FEF01", prod); end
        checks++;
        if (n != 9) begin errors++; $display("FAIL unsigned_busy_cycles got %0d want 9", n); end
        checks++;
        if (done !== 1'b1 || ed != 0) begin errors++; $display("FAIL unsigned_done got %b early=%0d", done, ed); end
    endtask

    task automatic test_ignore_start();
        int n;
        @(negedge clk);
        tc = 1'b1; mpd = 12'h123; mpr = 8'h05; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        tc = 1'b1; mpd = 12'hFFF; mpr = 8'h7F; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
        checks++;
        if (prod !== 20'h005AF) begin errors++; $display("FAIL ignore_start_prod got %h want 005AF", prod); end
        checks++;
        if (done !== 1'b1) begin errors++; $display("FAIL ignore_start_done got %b want 1", done); end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_queued got busy=%b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int n, ed;
        do_op(1'b0, 12'd100, 8'd200, n, ed);
        checks++;
        if (prod !== 20'h04E20 || done !== 1'b1) begin
            errors++; $display("FAIL b2b_first got prod=%h done=%b want 04E20/1", prod, done);
        end
        tc = 1'b1; mpd = 12'hFFF; mpr = 8'hFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_no_gap got busy=%b want 1", busy); end
        checks++;
        if (prod !== 20'h04E20 || done !== 1'b0) begin
            errors++; $display("FAIL b2b_prod_held got prod=%h done=%b want 04E20/0", prod, done);
        end
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(posedge clk); #1; end
        checks++;
        if (prod !== 20'h00001) begin errors++; $display("FAIL b2b_second_prod got %h want 00001", prod); end
        checks++;
        if (n != 8) begin errors++; $display("FAIL b2b_second_cycles got %0d want 8", n); end
    endtask

    task automatic test_reset_mid();
        int n, ed;
        @(negedge clk);
        tc = 1'b1; mpd = 12'h7FF; mpr = 8'h80; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL midreset_ctrl got busy=%b done=%b want 0/0", busy, done);
        end
        checks++;
        if (prod !== 20'h0) begin errors++; $display("FAIL midreset_prod got %h want 00000", prod); end
        rst_n = 1'b1;
        ed = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) ed++;
        end
        checks++;
        if (ed != 0) begin errors++; $display("FAIL midreset_resumed got %0d active cycles want 0", ed); end
        do_op(1'b1, 12'd5, 8'hFD, n, ed);
        checks++;
        if (prod !== 20'hFFFF1) begin errors++; $display("FAIL midreset_next_prod got %h want FFFF1", prod); end
        checks++;
        if (n != 8) begin errors++; $display("FAIL midreset_next_cycles got %0d want 8", n); end
    endtask

    task automatic test_sweep();
        logic [11:0] va [6] = '{12'h000, 12'h001, 12'h7FF, 12'h800, 12'hFFF, 12'h555};
        logic [7:0]  vb [6] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hAA};
        logic [19:0] e;
        int n, ed, p;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 6; j++) begin
                    if (t == 1) p = int'($signed(va[i])) * int'($signed(vb[j]));
                    else        p = int'(va[i]) * int'(vb[j]);
                    e = p[19:0];
                    do_op(t[0], va[i], vb[j], n, ed);
                    checks++;
                    if (prod !== e || n != (t == 1 ? 8 : 9) || done !== 1'b1) begin
                        errors++;
                        $display("FAIL sweep tc=%0d mpd=%h mpr=%h got %h/%0d/%b want %h/%0d/1",
                                 t, va[i], vb[j], prod, n, done, e, (t == 1 ? 8 : 9));
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_signed_corners();
        test_unsigned();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule : tb_mult_booth_seq

`default_nettype wire
